ram512_copy_engine: RTL and testbench

Sequential initiator that drives the write/read port of a RAM512 (512 x 16, synchronous read) to perform block copy or block fill operations without CPU involvement. It accepts a one-cycle start command and then walks the memory. For each word it either issues a read followed by a write (copy) or issues a write only (fill). It reports busy and signals completion with a one-cycle done pulse. It sits between the control logic and the RAM512 instance and owns that instance's `load`, `address` and `in` pins.

---
 rtl/ram512_copy_engine_if.sv | 29 ++
 rtl/ram512_copy_engine.sv | 100 ++++++++++
 tb/tb_ram512_copy_engine.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram512_copy_engine_if.sv
// Command/status and RAM512 port bundle for the block copy/fill engine.
// slave is the engine side; master is the controller plus the RAM.
interface ram512_copy_engine_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fill_value;
    logic              busy;
    logic              done;
    logic              mem_load;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    modport master (
        output start, mode, src, dst, len, fill_value, mem_out,
        input  busy, done, mem_load, mem_address, mem_in
    );

    modport slave (
        input  start, mode, src, dst, len, fill_value, mem_out,
        output busy, done, mem_load, mem_address, mem_in
    );
endinterface

// File: rtl/ram512_copy_engine.sv
// Block copy / block fill initiator owning the load, address and in pins of a RAM512.
// Copy spends a read cycle and a write cycle per word; fill writes one word per cycle.
module ram512_copy_engine #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
) (
    input logic                   clk,
    input logic                   reset,
    ram512_copy_engine_if.slave   bus
);
    typedef enum logic [2:0] {StIdle, StRead, StWrite, StFill, StDone} state_e;

    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [ADDR_W:0]   len_clamped;

    assign len_clamped = (bus.len > MaxLen) ? MaxLen : bus.len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        dst_d           = dst_q;
        rem_d           = rem_q;
        fill_d          = fill_q;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.mem_load    = 1'b0;
        bus.mem_address = '0;
        bus.mem_in      = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    src_d  = bus.src;
                    dst_d  = bus.dst;
                    rem_d  = len_clamped;
                    fill_d = bus.fill_value;
                    if (len_clamped == '0) begin
                        state_d = StDone;
                    end else if (bus.mode) begin
                        state_d = StFill;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                bus.busy        = 1'b1;
                bus.mem_address = src_q;
                state_d         = StWrite;
            end
            StWrite: begin
                // RAM out holds the word addressed during the preceding READ cycle.
                bus.busy        = 1'b1;
                bus.mem_load    = 1'b1;
                bus.mem_address = dst_q;
                bus.mem_in      = bus.mem_out;
                src_d           = src_q + 1'b1;
                dst_d           = dst_q + 1'b1;
                rem_d           = rem_q - 1'b1;
                state_d         = (rem_q == LenOne) ? StDone : StRead;
            end
            StFill: begin
                bus.busy        = 1'b1;
                bus.mem_load    = 1'b1;
                bus.mem_address = dst_q;
                bus.mem_in      = fill_q;
                dst_d           = dst_q + 1'b1;
                rem_d           = rem_q - 1'b1;
                state_d         = (rem_q == LenOne) ? StDone : StFill;
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_ram512_copy_engine.sv
// Directed bench for ram512_copy_engine with a behavioural RAM512 and a per-cycle
// scoreboard of expected read/write operations plus a reference memory image.
`timescale 1ns/1ps
module tb_ram512_copy_engine;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram512_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram512_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural RAM512 with registered read and backdoor init/preload.
    logic [DW-1:0] ram [512];
    logic          init_en = 1'b0;
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 512; i++) ram[i] <= DW'(i * 3 + 1);
        end else if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (bus.mem_load) begin
            ram[bus.mem_address] <= bus.mem_in;
        end
        bus.mem_out <= ram[bus.mem_address];
    end

    ev_t           exp_q[$];
    logic [DW-1:0] ref_mem [512];
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        int diffs = 0;
        for (int i = 0; i < 512; i++) if (ram[i] !== ref_mem[i]) diffs++;
        check(tag, diffs, 0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Pushes the expected op stream; only the first 'apply' writes update ref_mem.
    task automatic push_ops(input bit mode, input int src, input int dst, input int len,
                            input logic [DW-1:0] fv, input int apply);
        int n = (len > 512) ? 512 : len;
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] s = AW'(src + i);
            logic [AW-1:0] d = AW'(dst + i);
            logic [DW-1:0] w = mode ? fv : ref_mem[s];
            if (!mode) exp_q.push_back('{wr: 1'b0, addr: s, data: '0});
            exp_q.push_back('{wr: 1'b1, addr: d, data: w});
            if (i < apply) ref_mem[d] = w;
        end
    endtask

    // Called mid-cycle; start is sampled at the next edge, then inputs are scrambled.
    task automatic do_start(input bit mode, input int src, input int dst, input int len,
                            input logic [DW-1:0] fv);
        bus.mode = mode; bus.src = AW'(src); bus.dst = AW'(dst);
        bus.len = (AW+1)'(len); bus.fill_value = fv; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode = ~mode; bus.src = AW'($urandom); bus.dst = AW'($urandom);
        bus.len = (AW+1)'($urandom); bus.fill_value = DW'($urandom);
    endtask

    task automatic run(input int busy_exp, input int done_exp, input bit hold);
        int   nb = 0, dcyc = -1, extra = 0;
        ev_t  e;
        for (int cyc = 1; cyc <= done_exp + 4 && dcyc < 0; cyc++) begin
            @(negedge clk);
            if (hold && cyc == 2) begin
                bus.start = 1'b1; bus.mode = 1'b0; bus.len = 10'd7;
            end
            if (bus.busy) begin
                nb++;
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    e = exp_q.pop_front();
                    check("op_load", bus.mem_load, e.wr);
                    check("op_addr", bus.mem_address, e.addr);
                    if (e.wr) check("op_data", bus.mem_in, e.data);
                end
            end else begin
                check("load_outside_busy", bus.mem_load, 0);
            end
            if (bus.done) dcyc = cyc;
        end
        check("busy_cycles", nb, busy_exp);
        check("done_cycle", dcyc, done_exp);
        check("extra_ops", extra, 0);
        check("ops_left", exp_q.size(), 0);
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        check("idle_load", bus.mem_load, 0);
    endtask

    task automatic xfer(input bit mode, input int src, input int dst, input int len,
                        input logic [DW-1:0] fv, input bit hold);
        int n = (len > 512) ? 512 : len;
        push_ops(mode, src, dst, len, fv, 512);
        do_start(mode, src, dst, len, fv);
        if (n == 0)    run(0, 1, hold);
        else if (mode) run(n, n + 1, hold);
        else           run(2 * n, 2 * n + 1, hold);
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
        bus.len = '0; bus.fill_value = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = DW'(i * 3 + 1);
        reset = 1'b0;
        #1 reset = 1'b1;
        init_en = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_load", bus.mem_load, 0);
        check("rst_addr", bus.mem_address, 0);
        check("rst_in", bus.mem_in, 0);
        @(negedge clk);
        init_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Fill 10..13 with A5A5; neighbours 9 and 14 must survive.
        xfer(1'b1, 0, 10, 4, 16'hA5A5, 1'b0);
        check("fill_ram9", ram[9], ref_mem[9]);
        check("fill_ram14", ram[14], ref_mem[14]);
        check("fill_ram12", ram[12], 16'hA5A5);
        check_mem("mem_fill");

        preload(0, 16'd1); preload(1, 16'd2); preload(2, 16'd3);
        xfer(1'b0, 0, 100, 3, '0, 1'b0);
        check("copy_ram101", ram[101], 16'd2);
        check_mem("mem_copy");

        preload(510, 16'd7); preload(511, 16'd8);
        xfer(1'b0, 510, 0, 4, '0, 1'b0);
        check("wrap_ram2", ram[2], 16'd7);
        check("wrap_ram3", ram[3], 16'd8);
        check_mem("mem_wrap");

        xfer(1'b1, 0, 40, 0, 16'h1234, 1'b0);
        xfer(1'b0, 5, 40, 0, '0, 1'b0);
        check_mem("mem_len0");

        xfer(1'b1, 0, 300, 600, 16'h5A0F, 1'b0);
        check_mem("mem_len600");

        // Start re-asserted while busy and held through DONE must be ignored.
        xfer(1'b1, 0, 50, 3, 16'hBEEF, 1'b1);
        check_mem("mem_hold_start");

        for (int i = 0; i < 8; i++) preload(AW'(200 + i), DW'(16'h0C00 + i));
        push_ops(1'b0, 200, 300, 5, '0, 2);
        do_start(1'b0, 200, 300, 5, '0);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            check("mid_busy", bus.busy, 1);
        end
        @(negedge clk);
        check("mid_load_before_rst", bus.mem_load, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_load", bus.mem_load, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_addr", bus.mem_address, 0);
        check("mid_rst_in", bus.mem_in, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_ram301", ram[301], 16'h0C01);
        check_mem("mem_after_reset");

        xfer(1'b0, 300, 400, 2, '0, 1'b0);
        check_mem("mem_post_reset_copy");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
